// File: rtl/fir_decim_out.sv
// Scale, decimate and buffer FIR output samples; a kept sample reaches the FIFO head two edges after capture.
// No back-pressure to the filter: writes into a full FIFO are dropped and flagged on ovf; the consumer pops with out_ready.
module fir_decim_out #(
    parameter int DATA_W = 16,
    parameter int SHIFT  = 7,
    parameter int DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    in_valid,
    input  logic [3:0]              dec_m,
    input  logic                    clr_ovf,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [DATA_W:0] ROUND    = {{DATA_W{1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic [AW:0]     FULL_LVL = (AW + 1)'(DEPTH);

    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] scaled;
    logic [3:0]        cnt;
    logic              keep;
    logic              s1_valid;
    logic [DATA_W-1:0] s1_data;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              full;
    logic              pop;
    logic              wr_en;
    logic              drop;

    // One extra bit of headroom so the rounding add cannot wrap.
    assign sum    = {1'b0, in_data} + ROUND;
    assign scaled = DATA_W'(sum >> SHIFT);
    assign keep   = in_valid && (cnt == 4'd0);

    // Loading dec_m on a kept sample also covers M=1, since dec_m is then 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= 4'd0;
        end else if (in_valid) begin
            if (cnt == 4'd0) begin
                cnt <= dec_m;
            end else begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= keep;
            if (keep) begin
                s1_data <= scaled;
            end
        end
    end

    assign out_valid = (level != '0);
    assign full      = (level == FULL_LVL);
    assign pop       = out_valid && out_ready;
    // A pop on the same edge frees the head slot, so a full FIFO can still accept.
    assign wr_en     = s1_valid && (!full || pop);
    assign drop      = s1_valid && full && !pop;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= s1_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, pop})
                2'b10:   level <= level + (AW + 1)'(1);
                2'b01:   level <= level - (AW + 1)'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end else if (clr_ovf) begin
            ovf <= 1'b0;
        end
    end

    // Storage is not reset, so the head is masked until something has been written.
    assign out_data = out_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_fir_decim_out.sv
// Bench for fir_decim_out: queue-based reference model compared every cycle, plus literal directed checks.
module tb_fir_decim_out;
    localparam int DATA_W = 16;
    localparam int SHIFT  = 7;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_valid = 1'b0;
    logic [3:0]        dec_m = 4'd0;
    logic              clr_ovf = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [2:0]        level;
    logic              ovf;

    fir_decim_out #(.DATA_W(DATA_W), .SHIFT(SHIFT), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .dec_m(dec_m), .clr_ovf(clr_ovf), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .level(level), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit started = 1'b0;
    int maxlvl = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // Reference model: samples to skip before the next kept one, a value waiting
    // one edge before reaching the buffer, and the buffer as a plain queue.
    int m_q[$];
    int m_log[$];
    int dut_log[$];
    int m_skip = 0;
    bit m_pend = 1'b0;
    int m_pend_val = 0;
    bit m_ovf = 1'b0;
    bit m_pop, m_drop;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_q.delete();
            m_skip = 0;
            m_pend = 1'b0;
            m_ovf  = 1'b0;
        end else begin
            m_pop  = (m_q.size() > 0) && out_ready;
            m_drop = m_pend && (m_q.size() == DEPTH) && !m_pop;
            if (m_pop) m_log.push_back(m_q.pop_front());
            if (m_pend && !m_drop) m_q.push_back(m_pend_val);
            if (m_drop) m_ovf = 1'b1;
            else if (clr_ovf) m_ovf = 1'b0;
            m_pend = 1'b0;
            if (in_valid) begin
                if (m_skip == 0) begin
                    m_pend     = 1'b1;
                    m_pend_val = (int'(in_data) + (1 << (SHIFT - 1))) / (1 << SHIFT);
                    m_skip     = int'(dec_m);
                end else begin
                    m_skip = m_skip - 1;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (started && !reset) begin
            chk("out_valid", out_valid, m_q.size() > 0);
            chk("level", level, m_q.size());
            chk("ovf", ovf, m_ovf);
            chk("out_data", out_data, (m_q.size() > 0) ? m_q[0] : 0);
            if (int'(level) > maxlvl) maxlvl = int'(level);
        end
    end

    always @(negedge clk) begin
        if (started && !reset && out_valid && out_ready) dut_log.push_back(int'(out_data));
    end

    task automatic cyc(input logic v, input int d);
        @(posedge clk);
        #2;
        in_valid = v;
        in_data  = DATA_W'(d);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        reset = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b0;
        dut_log.delete();
        m_log.delete();
        maxlvl = 0;
    endtask

    task automatic chk_log(input string nm, input int exp[$]);
        chk({nm, "_cnt"}, dut_log.size(), exp.size());
        chk({nm, "_mcnt"}, m_log.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            chk(nm, (i < dut_log.size()) ? dut_log[i] : -1, exp[i]);
            chk({nm, "_model"}, (i < m_log.size()) ? m_log[i] : -1, exp[i]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_q[$];
        @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_level", level, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_data", out_data, 0);
        #1;
        reset = 1'b0;
        started = 1'b1;

        // M=1 streaming with the consumer always ready
        dec_m = 4'd0;
        out_ready = 1'b1;
        cyc(1, 128); cyc(1, 256); cyc(1, 64); cyc(1, 63);
        cyc(0, 0);
        repeat (4) @(posedge clk);
        exp_q = '{1, 2, 1, 0};
        chk_log("m1_stream", exp_q);

        // M=4: only every fourth sample survives
        do_reset();
        dec_m = 4'd3;
        out_ready = 1'b1;
        for (int k = 0; k < 12; k++) cyc(1, 128 * k);
        cyc(0, 0);
        repeat (4) @(posedge clk);
        exp_q = '{0, 4, 8};
        chk_log("m4_stream", exp_q);
        chk("m4_maxlvl", maxlvl, 1);

        // Overflow with a stalled consumer, then clear-vs-set priority
        do_reset();
        dec_m = 4'd0;
        out_ready = 1'b0;
        for (int k = 1; k <= 6; k++) cyc(1, 128 * k);
        cyc(0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("ovf_level", level, 4);
        chk("ovf_set", ovf, 1);
        cyc(1, 128 * 7);
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        clr_ovf = 1'b1;
        @(posedge clk);
        #1;
        chk("ovf_set_wins", ovf, 1);
        @(posedge clk);
        #1;
        chk("ovf_cleared", ovf, 0);
        #1;
        clr_ovf = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        exp_q = '{1, 2, 3, 4};
        chk_log("ovf_drain", exp_q);

        // Full FIFO with a pop and a write on the same edge
        do_reset();
        dec_m = 4'd0;
        out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) cyc(1, 128 * k);
        @(posedge clk);
        #1;
        chk("full_level", level, 4);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("full_pop_wr_level", level, 4);
        chk("full_pop_wr_ovf", ovf, 0);
        repeat (6) @(posedge clk);
        exp_q = '{1, 2, 3, 4, 5};
        chk_log("full_drain", exp_q);

        // Reset mid-stream with three entries buffered
        do_reset();
        dec_m = 4'd1;
        out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) cyc(1, 128 * k);
        cyc(0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("mid_level", level, 3);
        @(posedge clk);
        #4;
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_level", level, 0);
        chk("mid_rst_data", out_data, 0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        dut_log.delete();
        m_log.delete();
        out_ready = 1'b1;
        cyc(1, 128 * 9);
        @(posedge clk);
        #1;
        chk("lat_edge1_valid", out_valid, 0);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("lat_edge2_valid", out_valid, 1);
        chk("lat_edge2_data", out_data, 9);
        repeat (3) @(posedge clk);
        exp_q = '{9};
        chk_log("post_rst", exp_q);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fir_decim_out.md
FIR_DECIM_OUT -- requirements
Module: fir_decim_out

Interface
REQ-001 Parameter DATA_W, default 16: width of input and output samples.
REQ-002 Parameter SHIFT, default 7: coefficient scaling exponent to remove (filter coefficients are scaled by 2^SHIFT = 128).
REQ-003 Parameter DEPTH, default 4: output FIFO depth in entries; must be a power of 2 and at least 2.
REQ-004 clk  input  1  clock; all state updates on its rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 in_data  input  DATA_W  unsigned sample from the FIR output register.
REQ-007 in_valid  input  1  in_data holds a new sample this cycle; there is no back-pressure to the filter.
REQ-008 dec_m  input  4  decimation factor minus one; the factor M = dec_m+1, range 1..16.
REQ-009 clr_ovf  input  1  synchronous clear of ovf.
REQ-010 out_data  output  DATA_W  scaled, decimated sample at the FIFO head.
REQ-011 out_valid  output  1  out_data is valid (FIFO not empty).
REQ-012 out_ready  input  1  consumer accepts out_data this cycle.
REQ-013 level  output  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
REQ-014 ovf  output  1  sticky flag: a kept sample was dropped.

Function
REQ-015 Scaling: scaled = (in_data + 2^(SHIFT-1)) >> SHIFT, computed at DATA_W+1 bits (round half up) and zero-extended to DATA_W; no saturation is needed.
REQ-016 Decimation counter cnt (4 bit): counts only on cycles with in_valid=1; a sample is kept when cnt==0.
REQ-017 On a kept sample, cnt loads dec_m when dec_m>0 and stays 0 when dec_m=0. Otherwise cnt decrements.
REQ-018 dec_m is sampled only when a sample is kept; changes at other times take effect from the next kept sample.
REQ-019 The first in_valid sample after reset is always kept.
REQ-020 Stage 1 (scale register): on a kept sample, s1_data <= scaled and s1_valid <= 1; otherwise s1_valid <= 0.
REQ-021 Stage 2 (FIFO write): when s1_valid=1, s1_data is written on the next edge, subject to the full rule.
REQ-022 Latency: a kept sample at edge n, with the FIFO empty, appears at out_data with out_valid=1 after edge n+2.
REQ-023 Pop: a pop occurs on an edge where out_valid && out_ready. out_data is the registered FIFO head and is valid in the same cycle as out_valid.
REQ-024 Empty: when out_valid=0, out_ready is ignored; there is no underflow and no pointer change.
REQ-025 Full: a write with level==DEPTH and no pop in the same cycle is dropped and sets ovf=1. Pointers and data are unchanged.
REQ-026 Full with a pop in the same cycle: the write is accepted and level stays at DEPTH.
REQ-027 Simultaneous write and pop at any level: level is unchanged and FIFO order is preserved.
REQ-028 Pointers wrap modulo DEPTH.
REQ-029 ovf stays set until clr_ovf=1. If clr_ovf and a new drop occur in the same cycle, the set wins.
REQ-030 The decimation counter advances on every in_valid, whether or not the FIFO is full.

Reset
REQ-031 Reset clears cnt, s1_valid, both FIFO pointers, level, and ovf to 0, and drives out_valid=0.
REQ-032 Reset asserted mid-operation discards all buffered and in-flight samples immediately.
REQ-033 After reset release, the first in_valid sample is kept per REQ-019.
REQ-034 FIFO storage RAM is not reset; out_data is 0 while out_valid=0.

Verification
REQ-035 M=1 (dec_m=0), out_ready=1, in_data=128,256,64,63 on consecutive cycles -> out_data=1,2,1,0, each 2 cycles after its input.
REQ-036 dec_m=3, 12 consecutive valid samples of 128*k (k=0..11) -> outputs 0,4,8 only; level never exceeds 1.
REQ-037 dec_m=0, out_ready=0, 6 valid samples -> level=4, ovf=1, and the first 4 samples pop in order once out_ready=1.
REQ-038 level=4 with out_ready=1 and a write arriving in the same cycle -> level stays 4, ovf stays 0, no data is lost.
REQ-039 Reset pulse with level=3 mid-stream -> out_valid=0 and level=0 immediately; the next valid sample is kept and output 2 cycles later.
REQ-040 ovf=1, then clr_ovf=1 in the same cycle as a new drop -> ovf remains 1; clr_ovf alone -> ovf=0.
